// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// Module   : pipeline_stall_controller
// Function : Stall and flush scheduler for a 5-stage pipeline. It also runs the
//            req/gnt/rvalid handshake for the data memory, with a timeout.
// Options  : PIPE_PERF_CNT_EN adds saturating stall-cycle and flush counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] id_ex_registerrd_i,
  input  logic [REG_ADDR_W-1:0] if_id_registerrs1_i,
  input  logic [REG_ADDR_W-1:0] if_id_registerrs2_i,
  input  logic                  pcsrcE_i,
  input  logic                  ex_mem_mem_op_i,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  output logic                  dmem_req_o,
  output logic                  stallF_o,
  output logic                  stallD_o,
  output logic                  stallE_o,
  output logic                  stallM_o,
  output logic                  flushD_o,
  output logic                  flushE_o,
  output logic                  flushW_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]      perf_stall_cyc_o,
  output logic [CNT_W-1:0]      perf_flush_cnt_o,
`endif
  output logic                  dmem_err_o
);

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mem_stall;
  logic             mem_req;
  logic             mem_err;
  logic             load_use;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // The counter keeps running across REQ->WAIT, so the budget spans both states.
  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    mem_req   = 1'b0;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req   = ex_mem_mem_op_i;
        mem_stall = ex_mem_mem_op_i;
        if (ex_mem_mem_op_i) begin
          tmo_cnt_d = '0;
          state_d   = dmem_gnt_i ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req   = 1'b1;
        mem_stall = 1'b1;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (dmem_gnt_i) begin
          state_d = ST_WAIT;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q >= TMO_LAST) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        mem_stall = 1'b1;
        mem_err   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign load_use = id_ex_mem_read_i && (id_ex_registerrd_i != '0) &&
                    ((id_ex_registerrd_i == if_id_registerrs1_i) ||
                     (id_ex_registerrd_i == if_id_registerrs2_i));

  // Outputs are forced low while reset is held, independent of state.
  always_comb begin
    dmem_req_o = rst_n_i & mem_req;
    dmem_err_o = rst_n_i & mem_err;
    stallF_o   = 1'b0;
    stallD_o   = 1'b0;
    stallE_o   = 1'b0;
    stallM_o   = 1'b0;
    flushD_o   = 1'b0;
    flushE_o   = 1'b0;
    flushW_o   = 1'b0;
    if (rst_n_i) begin
      if (mem_stall) begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        stallE_o = 1'b1;
        stallM_o = 1'b1;
        flushW_o = 1'b1;
      end else if (pcsrcE_i) begin
        flushD_o = 1'b1;
        flushE_o = 1'b1;
      end else if (load_use) begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        flushE_o = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (stallF_o && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + CNT_W'(1);
    end
    if (flushD_o && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cyc_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule

`default_nettype wire
